// File: rtl/btn_pkg.sv
// Shared FSM encoding and default timing for button_conditioner.
// BUTTON_CONDITIONER_REPEAT_EN enables auto-repeat in the top.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 480000;
  localparam int unsigned DEF_REPEAT_DELAY    = 24000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 4800000;

  function automatic int unsigned umax(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button side-band bundle: raw active-low input and conditioned outputs.
// BUTTON_CONDITIONER_REPEAT_EN changes press_pulse cadence only.
interface button_conditioner_if;
  logic btn_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output btn_n,
    input  pressed,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_n,
    output pressed,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;
endmodule

// File: rtl/button_conditioner.sv
// Debounced button with press/release strobes.
// Define BUTTON_CONDITIONER_REPEAT_EN for auto-repeat press pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFFFFFF) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_* must be nonzero");
  end

  logic btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (~btn_n),
    .q   (btn_s)
  );

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          fsm_press;
  logic          rpt_pulse;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_press = 1'b0;
    rel_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          fsm_press = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int HW =
    $clog2(umax(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d, hold_tgt;
  logic          rep_q, rep_d;

  assign hold_tgt = rep_q ? PER_LAST : DLY_LAST;

  // Counts only while HELD persists; RELEASE_WAIT leaves it paused.
  always_comb begin
    hold_d    = hold_q;
    rep_d     = rep_q;
    rpt_pulse = 1'b0;
    if (fsm_press || state_d == IDLE) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (state_q == HELD && state_d == HELD) begin
      if (hold_q == hold_tgt) begin
        hold_d    = '0;
        rep_d     = 1'b1;
        rpt_pulse = 1'b1;
      end else if (!(&hold_q)) begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  assign press_d   = fsm_press | rpt_pulse;
  assign pressed_d = (state_d == HELD) ||
                     (state_d == RELEASE_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=8, DELAY=20, PERIOD=5).
// Expectations follow BUTTON_CONDITIONER_REPEAT_EN when defined.
module tb_button_conditioner;

  localparam int unsigned DB = 8;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   npulse;

  button_conditioner_if bus ();

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (bus.btn_n),
    .pressed       (bus.pressed),
    .press_pulse   (bus.press_pulse),
    .release_pulse (bus.release_pulse)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rpt_exp(input int i);
    if (i == 10) return 1'b1;
    if (REP && i >= 30 && ((i - 30) % RP) == 0)
      return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pressed", bus.pressed, 0);
    check("rst_pp", bus.press_pulse, 0);
    check("rst_rp", bus.release_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_pressed", bus.pressed, 0);

    // clean press, edge 0 = first edge sampling low
    @(negedge clk);
    bus.btn_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("p_pp@%0d", i),
            bus.press_pulse, i == 10);
      check($sformatf("p_pr@%0d", i),
            bus.pressed, i >= 10);
      check($sformatf("p_rp@%0d", i),
            bus.release_pulse, 0);
    end

    // 3-cycle release glitch while held
    @(negedge clk);
    bus.btn_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("g_pr@%0d", i), bus.pressed, 1);
      check($sformatf("g_rp@%0d", i),
            bus.release_pulse, 0);
      if (i == 2) begin
        @(negedge clk);
        bus.btn_n = 1'b0;
      end
    end

    // real release
    @(negedge clk);
    bus.btn_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("r_rp@%0d", i),
            bus.release_pulse, i == 10);
      check($sformatf("r_pr@%0d", i),
            bus.pressed, i < 10);
      if (!REP)
        check($sformatf("r_pp@%0d", i),
              bus.press_pulse, 0);
    end

    // bounces shorter than debounce
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.btn_n = 1'b0;
      repeat (5) begin
        tick();
        check("b_pp", bus.press_pulse, 0);
        check("b_pr", bus.pressed, 0);
      end
      @(negedge clk);
      bus.btn_n = 1'b1;
      repeat (5) begin
        tick();
        check("b_pp", bus.press_pulse, 0);
        check("b_pr", bus.pressed, 0);
      end
    end
    repeat (12) begin
      tick();
      check("b_rp", bus.release_pulse, 0);
    end

    // reset mid PRESS_WAIT, button still held
    @(negedge clk);
    bus.btn_n = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_pressed", bus.pressed, 0);
    check("mr_pp", bus.press_pulse, 0);
    check("mr_rp", bus.release_pulse, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.press_pulse === 1'b1) npulse++;
      check($sformatf("h_pp@%0d", i),
            bus.press_pulse, rpt_exp(i));
      check($sformatf("h_pr@%0d", i),
            bus.pressed, i >= 10);
      check($sformatf("h_rp@%0d", i),
            bus.release_pulse, 0);
    end
    check("h_npulse", npulse, REP ? 7 : 1);

    // async reset while held clears outputs before any edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_pressed", bus.pressed, 0);
    check("ar_pp", bus.press_pulse, 0);
    bus.btn_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) tick();
    check("end_pressed", bus.pressed, 0);
    check("end_rp", bus.release_pulse, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
